// File: rtl/sweep_pkg.sv
// Shared definitions for the exhaustive equivalence sweep: state encoding,
// default widths and the stimulus/response bit-order indices used by netlist wrappers.
package sweep_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int N_IN_DEF  = 5;
   localparam int N_OUT_DEF = 4;

   // stimulus bit order {z, y1, y0, x1, x0}
   localparam int IDX_X0 = 0;
   localparam int IDX_X1 = 1;
   localparam int IDX_Y0 = 2;
   localparam int IDX_Y1 = 3;
   localparam int IDX_Z  = 4;

   // response bit order {w1, w0, u1, u0}
   localparam int IDX_U0 = 0;
   localparam int IDX_U1 = 1;
   localparam int IDX_W0 = 2;
   localparam int IDX_W1 = 3;

endpackage

// File: rtl/miter_cmp.sv
// Combinational miter: flags any difference between the two netlist responses.
module miter_cmp #(
   parameter int N_OUT = 4
) (
   input  logic [N_OUT-1:0] resp_a,
   input  logic [N_OUT-1:0] resp_b,
   output logic             mism
);

   assign mism = (resp_a != resp_b);

endmodule

// File: rtl/exh_sweep_checker.sv
// Exhaustive stimulus sweep and compare around an original/simplified netlist pair.
// Optional STOP_ON_FAIL_EN: end the sweep on the edge that sees the first mismatch.
module exh_sweep_checker
   import sweep_pkg::*;
#(
   parameter int N_IN  = N_IN_DEF,
   parameter int N_OUT = N_OUT_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [N_OUT-1:0] resp_a,
   input  logic [N_OUT-1:0] resp_b,
   output logic [N_IN-1:0]  stim,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [N_IN:0]    fail_cnt,
   output logic [N_IN-1:0]  fail_vec,
   output logic [N_OUT-1:0] fail_a,
   output logic [N_OUT-1:0] fail_b
);

   localparam logic [N_IN-1:0] STIM_ZERO = {N_IN{1'b0}};
   localparam logic [N_IN-1:0] STIM_LAST = {N_IN{1'b1}};
   localparam logic [N_IN-1:0] STIM_ONE  = {{(N_IN-1){1'b0}}, 1'b1};
   localparam logic [N_IN:0]   CNT_ZERO  = {(N_IN+1){1'b0}};
   localparam logic [N_IN:0]   CNT_ONE   = {{N_IN{1'b0}}, 1'b1};
   localparam logic [N_IN:0]   CNT_MAX   = {1'b1, {N_IN{1'b0}}};
   localparam logic [N_OUT-1:0] RESP_ZERO = {N_OUT{1'b0}};

   state_t           state_r, state_nxt_s;
   logic [N_IN-1:0]  stim_r, stim_nxt_s;
   logic [N_IN:0]    fail_cnt_r, fail_cnt_nxt_s;
   logic [N_IN-1:0]  fail_vec_r, fail_vec_nxt_s;
   logic [N_OUT-1:0] fail_a_r, fail_a_nxt_s;
   logic [N_OUT-1:0] fail_b_r, fail_b_nxt_s;
   logic             first_r, first_nxt_s;
   logic             busy_r, done_r, pass_r;
   logic             mism_s, last_s, stop_s;

   miter_cmp #(.N_OUT(N_OUT)) u_miter (
      .resp_a (resp_a),
      .resp_b (resp_b),
      .mism   (mism_s)
   );

   assign last_s = (stim_r == STIM_LAST);

`ifdef STOP_ON_FAIL_EN
   assign stop_s = mism_s;
`else
   assign stop_s = 1'b0;
`endif

   // State, stimulus counter, capture registers and registered status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         stim_r     <= STIM_ZERO;
         fail_cnt_r <= CNT_ZERO;
         fail_vec_r <= STIM_ZERO;
         fail_a_r   <= RESP_ZERO;
         fail_b_r   <= RESP_ZERO;
         first_r    <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         pass_r     <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         stim_r     <= stim_nxt_s;
         fail_cnt_r <= fail_cnt_nxt_s;
         fail_vec_r <= fail_vec_nxt_s;
         fail_a_r   <= fail_a_nxt_s;
         fail_b_r   <= fail_b_nxt_s;
         first_r    <= first_nxt_s;
         busy_r     <= (state_nxt_s == SWEEP);
         done_r     <= (state_nxt_s == DONE);
         pass_r     <= (state_nxt_s == DONE) && (fail_cnt_nxt_s == CNT_ZERO);
      end
   end

   // Next-state decode; abort overrides start and the terminal vector
   always_comb begin
      state_nxt_s = state_r;
      if (abort) begin
         state_nxt_s = IDLE;
      end else begin
         case (state_r)
            IDLE, DONE: begin
               if (start) state_nxt_s = SWEEP;
               else       state_nxt_s = state_r;
            end
            SWEEP: begin
               if (last_s || stop_s) state_nxt_s = DONE;
               else                  state_nxt_s = SWEEP;
            end
            default: state_nxt_s = IDLE;
         endcase
      end
   end

   // Stimulus advance and first-mismatch capture
   always_comb begin
      stim_nxt_s     = stim_r;
      fail_cnt_nxt_s = fail_cnt_r;
      fail_vec_nxt_s = fail_vec_r;
      fail_a_nxt_s   = fail_a_r;
      fail_b_nxt_s   = fail_b_r;
      first_nxt_s    = first_r;
      if (abort) begin
         stim_nxt_s = STIM_ZERO;
      end else begin
         case (state_r)
            IDLE, DONE: begin
               if (start) begin
                  stim_nxt_s     = STIM_ZERO;
                  fail_cnt_nxt_s = CNT_ZERO;
                  fail_vec_nxt_s = STIM_ZERO;
                  fail_a_nxt_s   = RESP_ZERO;
                  fail_b_nxt_s   = RESP_ZERO;
                  first_nxt_s    = 1'b0;
               end else begin
                  stim_nxt_s = stim_r;
               end
            end
            SWEEP: begin
               if (mism_s) begin
                  if (fail_cnt_r != CNT_MAX) fail_cnt_nxt_s = fail_cnt_r + CNT_ONE;
                  else                       fail_cnt_nxt_s = fail_cnt_r;
                  if (!first_r) begin
                     fail_vec_nxt_s = stim_r;
                     fail_a_nxt_s   = resp_a;
                     fail_b_nxt_s   = resp_b;
                     first_nxt_s    = 1'b1;
                  end else begin
                     first_nxt_s = first_r;
                  end
               end else begin
                  fail_cnt_nxt_s = fail_cnt_r;
               end
               if (state_nxt_s == DONE) stim_nxt_s = STIM_ZERO;
               else                     stim_nxt_s = stim_r + STIM_ONE;
            end
            default: stim_nxt_s = STIM_ZERO;
         endcase
      end
   end

   assign stim     = stim_r;
   assign busy     = busy_r;
   assign done     = done_r;
   assign pass     = pass_r;
   assign fail_cnt = fail_cnt_r;
   assign fail_vec = fail_vec_r;
   assign fail_a   = fail_a_r;
   assign fail_b   = fail_b_r;

endmodule

// File: tb/tb_exh_sweep_checker.sv
// Directed self-checking bench for exh_sweep_checker (both STOP_ON_FAIL_EN builds).
module tb_exh_sweep_checker;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [3:0] resp_a, resp_b;
   logic [4:0] stim;
   logic       busy, done, pass;
   logic [5:0] fail_cnt;
   logic [4:0] fail_vec;
   logic [3:0] fail_a, fail_b;

   int         mode = 0;
   logic [4:0] fault_at = 5'd0;
   int         n_cmp = 0;
   int         n_fail = 0;
   int         cyc;

`ifdef STOP_ON_FAIL_EN
   localparam int         FAULT_AT   = 7;
   localparam int         FAULT_BUSY = 8;
   localparam logic [3:0] FAULT_A    = 4'b1111;
   localparam logic [3:0] FAULT_B    = 4'b1101;
   localparam int         INV_BUSY   = 1;
   localparam logic [5:0] INV_CNT    = 6'd1;
   localparam int         ABORT_MODE = 0;
   localparam logic [5:0] ABORT_CNT  = 6'd0;
`else
   localparam int         FAULT_AT   = 19;
   localparam int         FAULT_BUSY = 32;
   localparam logic [3:0] FAULT_A    = 4'b0010;
   localparam logic [3:0] FAULT_B    = 4'b0000;
   localparam int         INV_BUSY   = 32;
   localparam logic [5:0] INV_CNT    = 6'b100000;
   localparam int         ABORT_MODE = 2;
   localparam logic [5:0] ABORT_CNT  = 6'd12;
`endif

   exh_sweep_checker dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .resp_a(resp_a), .resp_b(resp_b), .stim(stim),
      .busy(busy), .done(done), .pass(pass), .fail_cnt(fail_cnt),
      .fail_vec(fail_vec), .fail_a(fail_a), .fail_b(fail_b)
   );

   always #5 clk = ~clk;

   // Stand-in netlists: fixed original function, simplified copy with selectable faults
   always_comb begin
      resp_a = {stim[4] ^ stim[0], stim[1] & stim[2], stim[3] | stim[0], stim[2] ^ stim[3]};
      case (mode)
         1:       resp_b = (stim == fault_at) ? (resp_a ^ 4'b0010) : resp_a;
         2:       resp_b = ~resp_a;
         default: resp_b = resp_a;
      endcase
   end

   task automatic run_sweep(output int cycles);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cycles = 0;
      while (busy && cycles < 100) begin
         cycles++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      n_cmp++; if (stim !== 5'd0)     begin n_fail++; $display("FAIL reset_stim got=%0d exp=0", stim); end
      n_cmp++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_cmp++; if (done !== 1'b0)     begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
      n_cmp++; if (pass !== 1'b0)     begin n_fail++; $display("FAIL reset_pass got=%b exp=0", pass); end
      n_cmp++; if (fail_cnt !== 6'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", fail_cnt); end
      n_cmp++; if ({fail_vec, fail_a, fail_b} !== 13'd0) begin n_fail++; $display("FAIL reset_capture got=%h exp=0", {fail_vec, fail_a, fail_b}); end
   endtask

   task automatic test_identical();
      mode = 0;
      run_sweep(cyc);
      n_cmp++; if (cyc != 32)         begin n_fail++; $display("FAIL ident_busy_cycles got=%0d exp=32", cyc); end
      n_cmp++; if (done !== 1'b1)     begin n_fail++; $display("FAIL ident_done got=%b exp=1", done); end
      n_cmp++; if (pass !== 1'b1)     begin n_fail++; $display("FAIL ident_pass got=%b exp=1", pass); end
      n_cmp++; if (fail_cnt !== 6'd0) begin n_fail++; $display("FAIL ident_cnt got=%0d exp=0", fail_cnt); end
      n_cmp++; if (fail_vec !== 5'd0) begin n_fail++; $display("FAIL ident_vec got=%0d exp=0", fail_vec); end
      n_cmp++; if (stim !== 5'd0)     begin n_fail++; $display("FAIL ident_stim got=%0d exp=0", stim); end
      repeat (3) @(negedge clk);
      n_cmp++; if ({busy, done, pass} !== 3'b011) begin n_fail++; $display("FAIL done_hold got=%b exp=011", {busy, done, pass}); end
   endtask

   task automatic test_fault();
      mode = 1;
      fault_at = 5'(FAULT_AT);
      run_sweep(cyc);
      n_cmp++; if (cyc != FAULT_BUSY)           begin n_fail++; $display("FAIL fault_busy_cycles got=%0d exp=%0d", cyc, FAULT_BUSY); end
      n_cmp++; if ({busy, done, pass} !== 3'b010) begin n_fail++; $display("FAIL fault_flags got=%b exp=010", {busy, done, pass}); end
      n_cmp++; if (fail_cnt !== 6'd1)           begin n_fail++; $display("FAIL fault_cnt got=%0d exp=1", fail_cnt); end
      n_cmp++; if (fail_vec !== 5'(FAULT_AT))   begin n_fail++; $display("FAIL fault_vec got=%0d exp=%0d", fail_vec, FAULT_AT); end
      n_cmp++; if (fail_a !== FAULT_A)          begin n_fail++; $display("FAIL fault_a got=%b exp=%b", fail_a, FAULT_A); end
      n_cmp++; if (fail_b !== FAULT_B)          begin n_fail++; $display("FAIL fault_b got=%b exp=%b", fail_b, FAULT_B); end
      n_cmp++; if (stim !== 5'd0)               begin n_fail++; $display("FAIL fault_stim got=%0d exp=0", stim); end
   endtask

   task automatic test_inverted();
      mode = 2;
      run_sweep(cyc);
      n_cmp++; if (cyc != INV_BUSY)       begin n_fail++; $display("FAIL inv_busy_cycles got=%0d exp=%0d", cyc, INV_BUSY); end
      n_cmp++; if (fail_cnt !== INV_CNT)  begin n_fail++; $display("FAIL inv_cnt got=%b exp=%b", fail_cnt, INV_CNT); end
      n_cmp++; if (fail_vec !== 5'd0)     begin n_fail++; $display("FAIL inv_vec got=%0d exp=0", fail_vec); end
      n_cmp++; if ({fail_a, fail_b} !== 8'b0000_1111) begin n_fail++; $display("FAIL inv_ab got=%b exp=00001111", {fail_a, fail_b}); end
      n_cmp++; if ({done, pass} !== 2'b10) begin n_fail++; $display("FAIL inv_verdict got=%b exp=10", {done, pass}); end
   endtask

   task automatic test_abort_restart();
      int n;
      mode = ABORT_MODE;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (stim != 5'd12 && n < 100) begin
         n++;
         @(negedge clk);
      end
      n_cmp++; if (stim !== 5'd12) begin n_fail++; $display("FAIL abort_reach12 got=%0d exp=12", stim); end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      n_cmp++; if ({busy, done, pass} !== 3'b000) begin n_fail++; $display("FAIL abort_flags got=%b exp=000", {busy, done, pass}); end
      n_cmp++; if (stim !== 5'd0)        begin n_fail++; $display("FAIL abort_stim got=%0d exp=0", stim); end
      n_cmp++; if (fail_cnt !== ABORT_CNT) begin n_fail++; $display("FAIL abort_cnt_kept got=%0d exp=%0d", fail_cnt, ABORT_CNT); end
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      n_cmp++; if ({busy, stim} !== 6'd0) begin n_fail++; $display("FAIL start_abort_idle got=%b exp=0", {busy, stim}); end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_cmp++; if ({busy, stim, fail_cnt} !== {1'b1, 5'd0, 6'd0}) begin n_fail++; $display("FAIL restart got=%b exp=1_00000_000000", {busy, stim, fail_cnt}); end
      @(negedge clk);
      n_cmp++; if (stim !== 5'd1) begin n_fail++; $display("FAIL restart_step got=%0d exp=1", stim); end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
   endtask

   task automatic test_async_reset();
      int n;
      mode = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (stim != 5'd10 && n < 100) begin
         n++;
         @(negedge clk);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if ({stim, busy, done, pass, fail_cnt, fail_vec, fail_a, fail_b} !== 28'd0) begin n_fail++; $display("FAIL async_reset got=%h exp=0", {stim, busy, done, pass, fail_cnt, fail_vec, fail_a, fail_b}); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++; if ({busy, done, stim} !== 7'd0) begin n_fail++; $display("FAIL post_reset_idle got=%b exp=0", {busy, done, stim}); end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_identical();
      test_fault();
      test_inverted();
      test_abort_restart();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
